multi_player_clock: RTL and testbench

MULTI_PLAYER_CLOCK -- requirements
Module: multi_player_clock

---
 rtl/multi_player_clock.sv | 145 ++++++++++++++
 tb/tb_multi_player_clock.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_player_clock.sv
// Multi-player game clock: per-player countdown timers with sudden death,
// Fischer increment and simple delay modes, plus registered PIO exports of
// the selected player's time and a packed status word.
module multi_player_clock #(
    parameter int NUM_PLAYERS = 2,
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_HZ     = 10,
    parameter int TIME_W      = 32
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic                   cfg_load,
    input  logic [TIME_W-1:0]      cfg_time,
    input  logic [15:0]            cfg_incr,
    input  logic [1:0]             cfg_mode,
    input  logic                   start,
    input  logic                   pause,
    input  logic [NUM_PLAYERS-1:0] player_done,
    input  logic [2:0]             rd_sel,
    output logic [31:0]            time_export,
    output logic [31:0]            mode_export
);

    localparam int DIV   = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [32:0] TIME_MAX = (33'd1 << TIME_W) - 33'd1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_EXPIRED  = 2'd3
    } state_t;

    state_t            state;
    logic [TIME_W-1:0] times [NUM_PLAYERS];
    logic [2:0]        active;
    logic [2:0]        expired;
    logic              flag;
    logic [15:0]       dly_cnt;
    logic [PRE_W-1:0]  presc;
    logic [15:0]       incr_q;
    logic [1:0]        mode_q;

    logic              tick;
    logic              dly_hold;
    logic              move_ok;
    logic              expire_now;
    logic [TIME_W-1:0] cur_time;
    logic [TIME_W-1:0] ticked_time;
    logic [TIME_W-1:0] inc_time;
    logic [32:0]       sum;
    logic [2:0]        next_active;

    // Active player's time after this cycle's tick, Fischer sum and move qualification
    always_comb begin
        cur_time = '0;
        move_ok  = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (active == 3'(i)) begin
                cur_time = times[i];
                move_ok  = player_done[i];
            end
        end
        tick        = (state == ST_RUNNING) && (presc == PRE_W'(DIV - 1));
        // Simple-delay mode burns the delay budget before touching the time
        dly_hold    = (mode_q == 2'd2) && (dly_cnt < incr_q);
        ticked_time = (tick && !dly_hold) ? cur_time - TIME_W'(1) : cur_time;
        // A tick that empties the clock beats a move in the same cycle
        expire_now  = tick && !dly_hold && (cur_time == TIME_W'(1));
        sum         = 33'(ticked_time) + 33'(incr_q);
        inc_time    = (sum > TIME_MAX) ? '1 : sum[TIME_W-1:0];
        next_active = (active == 3'(NUM_PLAYERS - 1)) ? 3'd0 : active + 3'd1;
    end

    // Game state machine, player times, prescaler and delay counter
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state   <= ST_IDLE;
            for (int i = 0; i < NUM_PLAYERS; i++) times[i] <= '0;
            active  <= '0;
            expired <= '0;
            flag    <= 1'b0;
            dly_cnt <= '0;
            presc   <= '0;
            incr_q  <= '0;
            mode_q  <= '0;
        end else if (cfg_load && state != ST_RUNNING) begin
            for (int i = 0; i < NUM_PLAYERS; i++) times[i] <= cfg_time;
            incr_q  <= cfg_incr;
            mode_q  <= cfg_mode;
            active  <= '0;
            dly_cnt <= '0;
            flag    <= 1'b0;
            state   <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_PAUSED: begin
                    if (start && !pause) begin
                        state <= ST_RUNNING;
                        presc <= '0;
                    end
                end
                ST_RUNNING: begin
                    if (cur_time == '0) begin
                        state   <= ST_EXPIRED;
                        flag    <= 1'b1;
                        expired <= active;
                    end else begin
                        presc <= tick ? '0 : presc + PRE_W'(1);
                        if (tick && dly_hold) dly_cnt <= dly_cnt + 16'd1;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (active == 3'(i)) begin
                                times[i] <= (move_ok && !expire_now && mode_q == 2'd1)
                                            ? inc_time : ticked_time;
                            end
                        end
                        if (move_ok && !expire_now) begin
                            active  <= next_active;
                            dly_cnt <= '0;
                        end
                        if (pause) state <= ST_PAUSED;
                    end
                end
                default: ; // EXPIRED waits for cfg_load or reset
            endcase
        end
    end

    // Registered PIO exports: selected player time and packed status word
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            time_export <= '0;
            mode_export <= '0;
        end else begin
            time_export <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (rd_sel == 3'(i)) time_export <= 32'(times[i]);
            end
            mode_export <= {18'd0, mode_q, 1'b0, expired, 1'b0, active,
                            1'b0, flag, state};
        end
    end

endmodule

// File: tb/tb_multi_player_clock.sv
// Directed bench for multi_player_clock with one tick every 10 clock cycles.
module tb_multi_player_clock;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [31:0] cfg_time;
    logic [15:0] cfg_incr;
    logic [1:0]  cfg_mode;
    logic        start;
    logic        pause;
    logic [1:0]  player_done;
    logic [2:0]  rd_sel;
    logic [31:0] time_export;
    logic [31:0] mode_export;

    int checks = 0;
    int errors = 0;

    multi_player_clock #(
        .NUM_PLAYERS(2), .CLK_HZ(10), .TICK_HZ(1), .TIME_W(32)
    ) dut (
        .clk_clk(clk), .reset_reset(rst), .cfg_load(cfg_load), .cfg_time(cfg_time),
        .cfg_incr(cfg_incr), .cfg_mode(cfg_mode), .start(start), .pause(pause),
        .player_done(player_done), .rd_sel(rd_sel), .time_export(time_export),
        .mode_export(mode_export)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks: everything is driven and sampled 1ns after a rising edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [31:0] t, input logic [15:0] inc, input logic [1:0] m);
        cfg_time = t; cfg_incr = inc; cfg_mode = m; cfg_load = 1'b1;
        cyc(1);
        cfg_load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
    endtask

    task automatic do_done(input logic [1:0] d);
        player_done = d;
        cyc(1);
        player_done = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(2);
        checks++;
        if (time_export !== 32'd0 || mode_export !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold: got time=%h mode=%h expected 0/0", time_export, mode_export);
        end
        rst = 1'b0;
        cyc(2);
        checks++;
        if (mode_export !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle: got mode=%h expected 00000000", mode_export);
        end
    endtask

    task automatic test_start_pause_same();
        do_load(32'd20, 16'd0, 2'd0);
        start = 1'b1; pause = 1'b1;
        cyc(1);
        start = 1'b0; pause = 1'b0;
        cyc(1);
        checks++;
        if (mode_export !== 32'h0 || time_export !== 32'd20) begin
            errors++;
            $display("FAIL start_pause_same: got mode=%h time=%0d expected 00000000/20", mode_export, time_export);
        end
    endtask

    task automatic test_sudden_death();
        do_load(32'd5, 16'd0, 2'd0);
        do_start();
        cyc(55);
        checks++;
        if (mode_export !== 32'h7) begin
            errors++;
            $display("FAIL sd_expired_mode: got %h expected 00000007", mode_export);
        end
        checks++;
        if (time_export !== 32'd0) begin
            errors++;
            $display("FAIL sd_time0: got %0d expected 0", time_export);
        end
        do_start();
        do_done(2'b01);
        cyc(1);
        checks++;
        if (mode_export !== 32'h7) begin
            errors++;
            $display("FAIL sd_expired_sticky: got %h expected 00000007", mode_export);
        end
    endtask

    task automatic test_fischer();
        do_load(32'd100, 16'd3, 2'd1);
        do_start();
        cyc(20);                 // two ticks: 98
        do_done(2'b01);          // 98 + 3
        cyc(1);
        checks++;
        if (time_export !== 32'd101) begin
            errors++;
            $display("FAIL fischer_time0: got %0d expected 101", time_export);
        end
        checks++;
        if (mode_export !== 32'h1011) begin
            errors++;
            $display("FAIL fischer_active1: got %h expected 00001011", mode_export);
        end
        do_done(2'b01);          // not the active player: ignored
        cyc(2);
        checks++;
        if (time_export !== 32'd101 || mode_export !== 32'h1011) begin
            errors++;
            $display("FAIL fischer_ignore: got time=%0d mode=%h expected 101/00001011", time_export, mode_export);
        end
        rd_sel = 3'd1;
        cyc(1);
        checks++;
        if (time_export !== 32'd100) begin
            errors++;
            $display("FAIL fischer_time1: got %0d expected 100", time_export);
        end
        do_load(32'd7, 16'd0, 2'd0);  // ignored while running
        cyc(1);
        checks++;
        if (time_export !== 32'd100 || mode_export !== 32'h1011) begin
            errors++;
            $display("FAIL load_in_running: got time=%0d mode=%h expected 100/00001011", time_export, mode_export);
        end
        rd_sel = 3'd5;
        cyc(1);
        checks++;
        if (time_export !== 32'd0) begin
            errors++;
            $display("FAIL rd_sel_range: got %0d expected 0", time_export);
        end
        rd_sel = 3'd0;
        do_pause();
    endtask

    task automatic test_delay();
        do_load(32'd100, 16'd2, 2'd2);
        do_start();
        cyc(40);                 // two delay ticks, two decrements: 98
        do_done(2'b01);
        cyc(1);
        checks++;
        if (time_export !== 32'd98) begin
            errors++;
            $display("FAIL delay_time0: got %0d expected 98", time_export);
        end
        cyc(13);
        rd_sel = 3'd1;
        cyc(1);
        checks++;
        if (time_export !== 32'd100) begin
            errors++;
            $display("FAIL delay_time1: got %0d expected 100", time_export);
        end
        checks++;
        if (mode_export !== 32'h2011) begin
            errors++;
            $display("FAIL delay_mode: got %h expected 00002011", mode_export);
        end
        cyc(15);                 // second delay tick, then first decrement
        checks++;
        if (time_export !== 32'd99) begin
            errors++;
            $display("FAIL delay_spent: got %0d expected 99", time_export);
        end
        rd_sel = 3'd0;
        do_pause();
    endtask

    task automatic test_saturate();
        do_load(32'hFFFF_FFFE, 16'd5, 2'd1);
        do_start();
        cyc(3);
        do_done(2'b01);
        cyc(1);
        checks++;
        if (time_export !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL saturate: got %h expected ffffffff", time_export);
        end
        do_pause();
    endtask

    task automatic test_tick_move_same();
        do_load(32'd1, 16'd0, 2'd0);
        do_start();
        cyc(9);
        do_done(2'b01);          // lands on the tick edge
        cyc(3);
        checks++;
        if (mode_export !== 32'h7 || time_export !== 32'd0) begin
            errors++;
            $display("FAIL tick_move_same: got mode=%h time=%0d expected 00000007/0", mode_export, time_export);
        end
    endtask

    task automatic test_pause_move();
        do_load(32'd50, 16'd4, 2'd1);
        do_start();
        cyc(3);
        player_done = 2'b01; pause = 1'b1;
        cyc(1);
        player_done = 2'b00; pause = 1'b0;
        cyc(1);
        checks++;
        if (time_export !== 32'd54 || mode_export !== 32'h1012) begin
            errors++;
            $display("FAIL pause_move: got time=%0d mode=%h expected 54/00001012", time_export, mode_export);
        end
    endtask

    task automatic test_pause_resume();
        do_load(32'd100, 16'd0, 2'd0);
        do_start();
        cyc(15);                 // one tick: 99
        do_pause();
        cyc(1);
        checks++;
        if (mode_export !== 32'h2 || time_export !== 32'd99) begin
            errors++;
            $display("FAIL paused: got mode=%h time=%0d expected 00000002/99", mode_export, time_export);
        end
        cyc(100);
        checks++;
        if (time_export !== 32'd99) begin
            errors++;
            $display("FAIL pause_hold: got %0d expected 99", time_export);
        end
        do_start();
        cyc(8);                  // prescaler restarted: no tick yet
        checks++;
        if (time_export !== 32'd99 || mode_export !== 32'h1) begin
            errors++;
            $display("FAIL resume_presc: got time=%0d mode=%h expected 99/00000001", time_export, mode_export);
        end
        cyc(3);
        checks++;
        if (time_export !== 32'd98) begin
            errors++;
            $display("FAIL resume_tick: got %0d expected 98", time_export);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (time_export !== 32'd0 || mode_export !== 32'd0) begin
            errors++;
            $display("FAIL reset_running: got time=%h mode=%h expected 0/0", time_export, mode_export);
        end
        cyc(1);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_time = '0; cfg_incr = '0; cfg_mode = '0;
        start = 1'b0; pause = 1'b0; player_done = '0; rd_sel = '0;
        #1;
        test_reset();
        test_start_pause_same();
        test_sudden_death();
        test_fischer();
        test_delay();
        test_saturate();
        test_tick_move_same();
        test_pause_move();
        test_pause_resume();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
